// File: rtl/xif_aes_sched.sv
// xif_aes_sched
// Issue/commit/result scheduler sitting between the CV32E40X eXtension
// interface and one multi-cycle masked AES32 functional unit. Offloaded
// AES32 instructions are buffered in program order. Each one is resolved
// by a commit or a kill. Committed instructions go to the FU one at a time
// with fresh masking randomness. Results come back over a held handshake.
//
// Ports
//   clk_i, rst_n            clock, asynchronous active-low reset
//   issue_*                 XIF issue request/response (combinational accept)
//   commit_*                XIF commit strobe: id plus kill flag
//   result_*                XIF result handshake, held until result_ready_i
//   fu_valid_o/fu_ready_i   operand handshake towards the AES32 unit
//   fu_rs1_o/fu_rs2_o       operands
//   fu_bs_o/fu_op_o         byte select and one-hot {encsm,encs,decsm,decs}
//   fu_rand_o               masking randomness, refreshed per dispatch
//   fu_done_i/fu_result_i   single-cycle result pulse from the unit
module xif_aes_sched #(
  parameter int          DEPTH       = 4,
  parameter int          X_ID_WIDTH  = 4,
  parameter int          X_RFR_WIDTH = 32,
  parameter logic [6:0]  AES32_OPC   = 7'b0101011,
  parameter logic [35:0] LFSR_SEED   = 36'h5A5A5A5A5
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic [2*X_RFR_WIDTH-1:0] issue_rs_i,
  input  logic [1:0]               issue_rs_valid_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_RFR_WIDTH-1:0]   result_data_o,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [4:0]               result_rd_o,
  output logic                     fu_valid_o,
  input  logic                     fu_ready_i,
  output logic [X_RFR_WIDTH-1:0]   fu_rs1_o,
  output logic [X_RFR_WIDTH-1:0]   fu_rs2_o,
  output logic [1:0]               fu_bs_o,
  output logic [3:0]               fu_op_o,
  output logic [35:0]              fu_rand_o,
  input  logic                     fu_done_i,
  input  logic [X_RFR_WIDTH-1:0]   fu_result_i
);

  localparam int         PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  // instr[29:25] encodings of the four accepted AES32 operations
  localparam logic [4:0] FUNCT_ESI  = 5'b10001;
  localparam logic [4:0] FUNCT_ESMI = 5'b10011;
  localparam logic [4:0] FUNCT_DSI  = 5'b10101;
  localparam logic [4:0] FUNCT_DSMI = 5'b10111;

  typedef enum logic [1:0] {FREE, PEND, COMMITTED, KILLED} entryState_e;
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, RESP} fsmState_e;

  entryState_e              entState_q [DEPTH];
  entryState_e              entState_d [DEPTH];
  logic [X_ID_WIDTH-1:0]    entId_q    [DEPTH];
  logic [4:0]               entRd_q    [DEPTH];
  logic [1:0]               entBs_q    [DEPTH];
  logic [3:0]               entOp_q    [DEPTH];
  logic [X_RFR_WIDTH-1:0]   entRs1_q   [DEPTH];
  logic [X_RFR_WIDTH-1:0]   entRs2_q   [DEPTH];

  logic [PW-1:0]            wrPtr_q, rdPtr_q;
  logic [PW:0]              count_q;
  logic                     readyEn_q;
  logic [35:0]              lfsr_q, rand_q, lfsrNext;
  logic [X_RFR_WIDTH-1:0]   result_q;
  fsmState_e                state_q, state_d;

  logic [3:0]               decOp;
  logic                     full, accept, popHead, startDispatch;
  logic                     unusedInstrBits;

  // Register-index and funct3 fields are not needed: operands arrive by value.
  assign unusedInstrBits = ^issue_instr_i[24:12];

  always_comb begin
    decOp = 4'b0000;
    unique case (issue_instr_i[29:25])
      FUNCT_ESMI: decOp = 4'b1000;
      FUNCT_ESI:  decOp = 4'b0100;
      FUNCT_DSMI: decOp = 4'b0010;
      FUNCT_DSI:  decOp = 4'b0001;
      default:    decOp = 4'b0000;
    endcase
  end

  // Ready comes from the registered count only, so a push never meets a full
  // buffer even when the head pops in the same cycle. readyEn_q keeps ready
  // low during reset and for the first cycle after release.
  assign full              = (count_q == FULL_COUNT);
  assign issue_ready_o     = readyEn_q & ~full;
  assign accept            = issue_valid_i & issue_ready_o &
                             (issue_instr_i[6:0] == AES32_OPC) &
                             (|decOp) & (issue_rs_valid_i == 2'b11);
  assign issue_accept_o    = accept;
  assign issue_writeback_o = accept;

  assign popHead = ((state_q == IDLE) && (entState_q[rdPtr_q] == KILLED)) ||
                   ((state_q == RESP) && result_ready_i);

  // The commit search also covers the entry being pushed this cycle. That
  // lets the core commit an instruction in the same cycle it is issued.
  always_comb begin
    entState_d = entState_q;
    if (popHead) entState_d[rdPtr_q] = FREE;
    if (accept)  entState_d[wrPtr_q] = PEND;
    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((entState_d[i] == PEND) &&
            (((accept && (wrPtr_q == PW'(i))) ? issue_id_i : entId_q[i]) == commit_id_i))
          entState_d[i] = commit_kill_i ? KILLED : COMMITTED;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entState_q[i] <= FREE;
        entId_q[i]    <= '0;
        entRd_q[i]    <= '0;
        entBs_q[i]    <= '0;
        entOp_q[i]    <= '0;
        entRs1_q[i]   <= '0;
        entRs2_q[i]   <= '0;
      end
    end else begin
      entState_q <= entState_d;
      if (accept) begin
        entId_q[wrPtr_q]  <= issue_id_i;
        entRd_q[wrPtr_q]  <= issue_instr_i[11:7];
        entBs_q[wrPtr_q]  <= issue_instr_i[31:30];
        entOp_q[wrPtr_q]  <= decOp;
        entRs1_q[wrPtr_q] <= issue_rs_i[X_RFR_WIDTH-1:0];
        entRs2_q[wrPtr_q] <= issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      readyEn_q <= 1'b0;
    end else begin
      readyEn_q <= 1'b1;
      if (accept)  wrPtr_q <= wrPtr_q + 1'b1;
      if (popHead) rdPtr_q <= rdPtr_q + 1'b1;
      unique case ({accept, popHead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // 36 Fibonacci steps (taps 36,25) per dispatch, so consecutive dispatches
  // get fully disjoint randomness words.
  function automatic logic [35:0] lfsrAdvance36(input logic [35:0] s);
    logic [35:0] v;
    v = s;
    for (int k = 0; k < 36; k++) v = {v[34:0], v[35] ^ v[24]};
    return v;
  endfunction

  assign lfsrNext      = lfsrAdvance36(lfsr_q);
  assign startDispatch = (state_q == IDLE) && (state_d == DISPATCH);
  assign fu_rand_o     = rand_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_SEED;
      rand_q   <= '0;
      result_q <= '0;
    end else begin
      if (startDispatch) begin
        lfsr_q <= lfsrNext;
        rand_q <= lfsrNext;
      end
      if ((state_q == WAIT) && fu_done_i) result_q <= fu_result_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: only the head is served, and only once it is committed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (entState_q[rdPtr_q] == COMMITTED) state_d = DISPATCH;
      DISPATCH: if (fu_ready_i)                       state_d = WAIT;
      WAIT:     if (fu_done_i)                        state_d = RESP;
      RESP:     if (result_ready_i)                   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: payloads are zeroed outside the state that presents them
  always_comb begin
    fu_valid_o     = 1'b0;
    fu_rs1_o       = '0;
    fu_rs2_o       = '0;
    fu_bs_o        = '0;
    fu_op_o        = '0;
    result_valid_o = 1'b0;
    result_data_o  = '0;
    result_id_o    = '0;
    result_rd_o    = '0;
    unique case (state_q)
      DISPATCH: begin
        fu_valid_o = 1'b1;
        fu_rs1_o   = entRs1_q[rdPtr_q];
        fu_rs2_o   = entRs2_q[rdPtr_q];
        fu_bs_o    = entBs_q[rdPtr_q];
        fu_op_o    = entOp_q[rdPtr_q];
      end
      RESP: begin
        result_valid_o = 1'b1;
        result_data_o  = result_q;
        result_id_o    = entId_q[rdPtr_q];
        result_rd_o    = entRd_q[rdPtr_q];
      end
      default: ;
    endcase
  end

endmodule
